// File: rtl/vram_access_scheduler_pkg.sv
// Shared constants and CPU FSM encoding for the VRAM access scheduler.
// No logic; sizes and default fetch-window geometry only.
package vram_access_scheduler_pkg;

    localparam int VRAM_ADDR_W         = 14;
    localparam int VRAM_DATA_W         = 32;
    localparam int FETCH_H_START_DEF   = 141;
    localparam int FETCH_H_END_DEF     = 789;
    localparam int FETCH_V_START_DEF   = 44;
    localparam int FETCH_V_END_DEF     = 524;
    localparam int CPU_MAX_WAIT_DEF    = 64;

    typedef enum logic [1:0] {
        CPU_IDLE    = 2'd0,
        CPU_ACK     = 2'd1,
        CPU_HOLDOFF = 2'd2
    } cpu_state_e;

    // Counter must be able to hold max_wait itself, not just max_wait-1.
    function automatic int wait_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/vram_access_scheduler_fetch_window_decode.sv
// Decodes raster position into the GPU fetch-window flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a pure function of h/v position.
module fetch_window_decode
    import vram_access_scheduler_pkg::*;
#(
    parameter int H_START = FETCH_H_START_DEF,
    parameter int H_END   = FETCH_H_END_DEF,
    parameter int V_START = FETCH_V_START_DEF,
    parameter int V_END   = FETCH_V_END_DEF
) (
    input  logic [11:0] h_count_i,
    input  logic [11:0] v_count_i,
    output logic        fetch_window_o
);

    localparam logic [11:0] H_S = 12'(H_START);
    localparam logic [11:0] H_E = 12'(H_END);
    localparam logic [11:0] V_S = 12'(V_START);
    localparam logic [11:0] V_E = 12'(V_END);

    // V_START names the line before the first fetch line, hence the strict compare.
    assign fetch_window_o = (h_count_i >= H_S) && (h_count_i <= H_E) &&
                            (v_count_i >  V_S) && (v_count_i <= V_E);

endmodule

// File: rtl/vram_access_scheduler.sv
// Arbitrates a single VRAM port between the pipelined GPU reader and a CPU.
// Latency: access issues combinationally; GPU data and CPU ack follow one cycle later.
// Backpressure: loser of arbitration stalls; CPU is spaced by ACK/HOLDOFF, GPU can grant every cycle.
module vram_access_scheduler
    import vram_access_scheduler_pkg::*;
#(
    parameter int ADDR_W        = VRAM_ADDR_W,
    parameter int DATA_W        = VRAM_DATA_W,
    parameter int FETCH_H_START = FETCH_H_START_DEF,
    parameter int FETCH_H_END   = FETCH_H_END_DEF,
    parameter int FETCH_V_START = FETCH_V_START_DEF,
    parameter int FETCH_V_END   = FETCH_V_END_DEF,
    parameter int CPU_MAX_WAIT  = CPU_MAX_WAIT_DEF
) (
    input  logic              clkPixel,
    input  logic              resetn,
    input  logic [11:0]       h_count,
    input  logic [11:0]       v_count,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_grant,
    output logic              gpu_rdata_valid,
    output logic [DATA_W-1:0] gpu_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              vram_en,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              fetch_window,
    output logic              cpu_starved
);

    localparam int              WAIT_W   = wait_cnt_w(CPU_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    cpu_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starved_q, starved_d;
    logic              gpu_vld_q;
    logic              cpu_issue;

    fetch_window_decode #(
        .H_START (FETCH_H_START),
        .H_END   (FETCH_H_END),
        .V_START (FETCH_V_START),
        .V_END   (FETCH_V_END)
    ) u_window (
        .h_count_i      (h_count),
        .v_count_i      (v_count),
        .fetch_window_o (fetch_window)
    );

    // Inside the window the GPU owns the port whenever it asks; outside, an idle CPU wins.
    always_comb begin
        cpu_issue  = resetn && (state_q == CPU_IDLE) && cpu_req && !(fetch_window && gpu_req);
        gpu_grant  = resetn && gpu_req && !cpu_issue;
        vram_en    = cpu_issue || gpu_grant;
        vram_we    = cpu_issue && cpu_we;
        vram_addr  = cpu_issue ? cpu_addr : gpu_addr;
        vram_wdata = cpu_wdata;
    end

    always_comb begin
        state_d = state_q;
        cpu_ack = 1'b0;
        case (state_q)
            CPU_IDLE:    if (cpu_issue) state_d = CPU_ACK;
            CPU_ACK: begin
                cpu_ack = resetn;
                state_d = CPU_HOLDOFF;
            end
            CPU_HOLDOFF: state_d = CPU_IDLE;
            default:     state_d = CPU_IDLE;
        endcase
    end

    always_comb begin
        wait_d = '0;
        if ((state_q == CPU_IDLE) && cpu_req && !cpu_issue) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end
        if (wait_d == WAIT_MAX) begin
            starved_d = 1'b1;
        end else if ((h_count == '0) && (v_count == '0)) begin
            starved_d = 1'b0;
        end else begin
            starved_d = starved_q;
        end
    end

    always_ff @(posedge clkPixel) begin
        if (!resetn) begin
            state_q   <= CPU_IDLE;
            wait_q    <= '0;
            starved_q <= 1'b0;
            gpu_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            starved_q <= starved_d;
            gpu_vld_q <= gpu_grant;
        end
    end

    assign gpu_rdata_valid = gpu_vld_q;
    assign gpu_rdata       = vram_rdata;
    assign cpu_rdata       = vram_rdata;
    assign cpu_starved     = starved_q;

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a synchronous VRAM model and
// queue-based scoreboards for GPU read data and CPU acks.
module tb_vram_access_scheduler;

    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] data;
    } ack_exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [11:0]   h_count, v_count;
    logic          gpu_req;
    logic [AW-1:0] gpu_addr;
    logic          gpu_grant, gpu_rdata_valid;
    logic [DW-1:0] gpu_rdata;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vram_en, vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata;
    logic          fetch_window, cpu_starved;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] gpu_q[$];
    ack_exp_t      ack_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    vram_access_scheduler dut (
        .clkPixel        (clk),
        .resetn          (resetn),
        .h_count         (h_count),
        .v_count         (v_count),
        .gpu_req         (gpu_req),
        .gpu_addr        (gpu_addr),
        .gpu_grant       (gpu_grant),
        .gpu_rdata_valid (gpu_rdata_valid),
        .gpu_rdata       (gpu_rdata),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .vram_en         (vram_en),
        .vram_we         (vram_we),
        .vram_addr       (vram_addr),
        .vram_wdata      (vram_wdata),
        .vram_rdata      (vram_rdata),
        .fetch_window    (fetch_window),
        .cpu_starved     (cpu_starved)
    );

    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata     <= mem[vram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs mid-cycle; a granted GPU read queues its expected data.
    task automatic sample(input bit exp_grant);
        @(negedge clk);
        chk("gpu_grant", 32'(gpu_grant), 32'(exp_grant));
        if (exp_grant) begin
            chk("gpu_port_en",   32'(vram_en),   32'd1);
            chk("gpu_port_we",   32'(vram_we),   32'd0);
            chk("gpu_port_addr", 32'(vram_addr), 32'(gpu_addr));
            gpu_q.push_back(mem[gpu_addr]);
        end
    endtask

    always @(negedge clk) begin
        if (gpu_rdata_valid) begin
            if (gpu_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL gpu_rdata_valid: unexpected valid, data 0x%08h at %0t", gpu_rdata, $time);
            end else begin
                chk("gpu_rdata", gpu_rdata, gpu_q.pop_front());
            end
        end
        if (cpu_ack) begin
            if (ack_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cpu_ack: unexpected ack, expected none at %0t", $time);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                n_checks++;
                if (e.rd) chk("cpu_rdata", cpu_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] wh [6];
        logic [11:0] wv [6];
        logic        wx [6];
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 ^ i;
        vram_rdata = '0;
        resetn = 1'b0; h_count = '0; v_count = '0;
        gpu_req = 1'b0; gpu_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset: requests present but everything held off.
        adv();
        gpu_req = 1'b1; cpu_req = 1'b1;
        sample(0);
        chk("rst_vram_en", 32'(vram_en), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_gpu_vld", 32'(gpu_rdata_valid), 32'd0);
        chk("rst_starved", 32'(cpu_starved), 32'd0);
        adv();
        gpu_req = 1'b0; cpu_req = 1'b0; resetn = 1'b1;
        sample(0);
        adv();

        // Window closed: CPU write beats GPU.
        gpu_req = 1'b1; gpu_addr = 14'h020;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h010; cpu_wdata = 32'hDEADBEEF;
        sample(0);
        chk("s1_en",    32'(vram_en),   32'd1);
        chk("s1_we",    32'(vram_we),   32'd1);
        chk("s1_addr",  32'(vram_addr), 32'h10);
        chk("s1_wdata", vram_wdata,     32'hDEADBEEF);
        ack_q.push_back('{rd: 1'b0, data: '0});
        adv();
        sample(1);
        chk("s1_ack", 32'(cpu_ack), 32'd1);
        adv();
        cpu_req = 1'b0;
        sample(1);
        chk("s1_ack_gone", 32'(cpu_ack), 32'd0);
        adv();
        gpu_req = 1'b0;
        sample(0);
        chk("s1_idle_en", 32'(vram_en), 32'd0);
        adv();

        // Window open: GPU streams 10 reads, CPU read waits then returns DEADBEEF.
        h_count = 12'd200; v_count = 12'd100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
        gpu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gpu_addr = 14'(14'h100 + i);
            sample(1);
            if (i == 0) chk("s2_window", 32'(fetch_window), 32'd1);
            adv();
        end
        gpu_req = 1'b0;
        sample(0);
        chk("s2_cpu_en",   32'(vram_en),   32'd1);
        chk("s2_cpu_we",   32'(vram_we),   32'd0);
        chk("s2_cpu_addr", 32'(vram_addr), 32'h10);
        ack_q.push_back('{rd: 1'b1, data: 32'hDEADBEEF});
        adv();
        sample(0);
        chk("s2_ack", 32'(cpu_ack), 32'd1);
        adv();
        cpu_req = 1'b0;
        sample(0);
        adv();

        // Issue at h=140, ack at h=141 alongside a GPU grant.
        h_count = 12'd140; gpu_req = 1'b1; gpu_addr = 14'h200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
        sample(0);
        chk("s3_window_140", 32'(fetch_window), 32'd0);
        chk("s3_cpu_en",     32'(vram_en),      32'd1);
        chk("s3_cpu_addr",   32'(vram_addr),    32'h10);
        ack_q.push_back('{rd: 1'b1, data: 32'hDEADBEEF});
        adv();
        h_count = 12'd141;
        sample(1);
        chk("s3_window_141", 32'(fetch_window), 32'd1);
        chk("s3_ack",        32'(cpu_ack),      32'd1);
        adv();
        h_count = 12'd142; cpu_req = 1'b0;
        sample(1);
        adv();
        gpu_req = 1'b0;
        sample(0);
        adv();

        // Starvation: CPU locked out inside the window for 64 cycles.
        h_count = 12'd200; v_count = 12'd100;
        gpu_req = 1'b1; gpu_addr = 14'h300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h030;
        for (int k = 0; k <= 64; k++) begin
            sample(1);
            if (k == 0)  chk("s4_starved_k0",  32'(cpu_starved), 32'd0);
            if (k == 63) chk("s4_starved_k63", 32'(cpu_starved), 32'd0);
            if (k == 64) chk("s4_starved_k64", 32'(cpu_starved), 32'd1);
            adv();
        end
        cpu_req = 1'b0; gpu_req = 1'b0;
        sample(0);
        chk("s4_sticky", 32'(cpu_starved), 32'd1);
        adv();
        h_count = 12'd5; v_count = 12'd0;
        sample(0);
        chk("s4_sticky_h5", 32'(cpu_starved), 32'd1);
        adv();
        h_count = 12'd0; v_count = 12'd0;
        sample(0);
        chk("s4_sticky_at_origin", 32'(cpu_starved), 32'd1);
        adv();
        h_count = 12'd10; v_count = 12'd100;
        sample(0);
        chk("s4_cleared", 32'(cpu_starved), 32'd0);
        adv();

        // Reset in the ACK cycle swallows the ack; FSM is idle straight after.
        h_count = 12'd0; v_count = 12'd100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h040; cpu_wdata = 32'h12345678;
        sample(0);
        chk("s5_issue_en", 32'(vram_en), 32'd1);
        chk("s5_issue_we", 32'(vram_we), 32'd1);
        adv();
        resetn = 1'b0; gpu_req = 1'b1; cpu_we = 1'b0;
        sample(0);
        chk("s5_rst_ack", 32'(cpu_ack), 32'd0);
        chk("s5_rst_en",  32'(vram_en), 32'd0);
        adv();
        resetn = 1'b1; gpu_req = 1'b0;
        sample(0);
        chk("s5_post_gpu_vld", 32'(gpu_rdata_valid), 32'd0);
        chk("s5_post_starved", 32'(cpu_starved),     32'd0);
        chk("s5_post_ack",     32'(cpu_ack),         32'd0);
        chk("s5_idle_issue",   32'(vram_en),         32'd1);
        chk("s5_idle_we",      32'(vram_we),         32'd0);
        chk("s5_idle_addr",    32'(vram_addr),       32'h40);
        ack_q.push_back('{rd: 1'b1, data: 32'h12345678});
        adv();
        cpu_req = 1'b0;
        sample(0);
        chk("s5_ack", 32'(cpu_ack), 32'd1);
        adv();
        sample(0);
        adv();

        // One-cycle CPU pulse lost to the GPU inside the window.
        h_count = 12'd200; v_count = 12'd100;
        gpu_req = 1'b1; gpu_addr = 14'h400;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h050; cpu_wdata = 32'hBAD0BAD0;
        sample(1);
        adv();
        cpu_req = 1'b0;
        sample(1);
        chk("s6_no_ack1", 32'(cpu_ack), 32'd0);
        adv();
        gpu_req = 1'b0;
        sample(0);
        chk("s6_port_idle", 32'(vram_en), 32'd0);
        chk("s6_no_ack2",   32'(cpu_ack), 32'd0);
        adv();
        sample(0);
        chk("s6_no_ack3", 32'(cpu_ack), 32'd0);
        chk("s6_mem_untouched", mem[14'h050], 32'hC0DE0050);
        adv();

        // Window edges.
        wh = '{12'd141, 12'd789, 12'd790, 12'd300, 12'd300, 12'd300};
        wv = '{12'd45,  12'd524, 12'd100, 12'd44,  12'd525, 12'd524};
        wx = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int i = 0; i < 6; i++) begin
            h_count = wh[i]; v_count = wv[i];
            sample(0);
            chk("window_edge", 32'(fetch_window), 32'(wx[i]));
            adv();
        end

        repeat (3) adv();
        chk("gpu_q_drained", 32'(gpu_q.size()), 32'd0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_access_scheduler.md
VRAM_ACCESS_SCHEDULER -- requirements
Module: vram_access_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 14: VRAM address width.
- DATA_W, 32: VRAM data width.
- FETCH_H_START, 141: first h_count of the GPU fetch window.
- FETCH_H_END, 789: last h_count of the GPU fetch window.
- FETCH_V_START, 44: v_count just before the first fetch line.
- FETCH_V_END, 524: last fetch line.
- CPU_MAX_WAIT, 64: CPU wait cycles before the starvation flag is set.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clkPixel, in, 1: the only clock.
- resetn, in, 1: synchronous, active-low reset.
- h_count, in, 12: pixel position from the timing generator.
- v_count, in, 12: line position from the timing generator.
- gpu_req, in, 1: renderer read request.
- gpu_addr, in, ADDR_W: renderer read address.
- gpu_grant, out, 1: renderer read is issued this cycle.
- gpu_rdata_valid, out, 1: gpu_rdata holds the data for the read granted last cycle.
- gpu_rdata, out, DATA_W: renderer read data.
- cpu_req, in, 1: CPU access request, held high until acknowledged.
- cpu_we, in, 1: CPU access is a write.
- cpu_addr, in, ADDR_W: CPU access address.
- cpu_wdata, in, DATA_W: CPU write data.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_rdata, out, DATA_W: CPU read data, valid with cpu_ack.
- vram_en, out, 1: VRAM port enable.
- vram_we, out, 1: VRAM port write enable.
- vram_addr, out, ADDR_W: VRAM port address.
- vram_wdata, out, DATA_W: VRAM port write data.
- vram_rdata, in, DATA_W: VRAM read data, one cycle after an enabled read.
- fetch_window, out, 1: the fetch window is open.
- cpu_starved, out, 1: sticky starvation flag.

Function
REQ-003 The fetch_window output SHALL be combinational:
- High when FETCH_H_START <= h_count <= FETCH_H_END.
- And FETCH_V_START < v_count <= FETCH_V_END.
REQ-004 The VRAM port SHALL be driven combinationally. At most one access is issued per cycle; the issuing requester is the only one that owns it that cycle.
REQ-005 Priority SHALL depend on the window:
- Window open: gpu_req wins over cpu_req.
- Window closed: an eligible CPU request wins over gpu_req.
REQ-006 While the window is closed, gpu_grant SHALL still assert whenever gpu_req is high and no CPU access issues that cycle.
REQ-007 The CPU FSM SHALL have three states, IDLE, ACK and HOLDOFF, with these transitions:
- IDLE -> ACK on the cycle a CPU access issues. The port carries cpu_addr, cpu_we and cpu_wdata.
- ACK -> HOLDOFF unconditionally. cpu_ack is high; for a read, cpu_rdata = vram_rdata.
- HOLDOFF -> IDLE unconditionally. cpu_req is ignored in this state.
REQ-008 A CPU request SHALL be eligible only in IDLE.
REQ-009 The minimum CPU access period SHALL be 3 cycles: issue, ACK, HOLDOFF.
REQ-010 In ACK and HOLDOFF the VRAM port SHALL be free for GPU grants.
REQ-011 GPU reads SHALL be fully pipelined:
- One grant per cycle is possible.
- gpu_rdata_valid is high exactly one cycle after each gpu_grant.
- gpu_rdata = vram_rdata in that cycle.
REQ-012 If cpu_req drops before it issues, no access SHALL occur and no ack is produced.
REQ-013 A CPU access issued just before the window opens SHALL complete normally; its ACK cycle does not use the port.
REQ-014 cpu_rdata SHALL be undefined on write acks. On read acks it equals the VRAM data at the addressed location.
REQ-015 The wait counter SHALL behave as follows:
- It increments each cycle cpu_req is high in IDLE without issuing.
- It saturates at CPU_MAX_WAIT.
- It clears on issue or when cpu_req is low.
REQ-016 cpu_starved SHALL be sticky:
- Set when the wait counter reaches CPU_MAX_WAIT.
- Cleared when h_count == 0 and v_count == 0.
- If set and clear conditions coincide, set wins.
REQ-017 The port idle value SHALL be vram_en = 0 and vram_we = 0. vram_addr and vram_wdata are don't-care when vram_en = 0.

Reset
REQ-018 While resetn is low at a clkPixel edge, the block SHALL reset:
- CPU FSM to IDLE.
- cpu_ack, gpu_rdata_valid and cpu_starved to 0.
- Wait counter to 0.
REQ-019 A reset during ACK SHALL suppress the ack. An access issued in the reset cycle is not acknowledged.
REQ-020 While resetn is low, vram_en and gpu_grant SHALL be forced to 0.

Structure
REQ-021 The GPU shared package SHALL hold:
- The default fetch-window constants.
- The CPU FSM state encoding.
- ADDR_W and DATA_W defaults.
REQ-022 The window comparison SHALL be one sub-module, fetch_window_decode, containing only combinational compares. All sequential logic stays in vram_access_scheduler.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Window closed, cpu_req write to addr 0x0010, data 0xDEADBEEF, gpu_req high -> CPU issues in cycle 0 with vram_we = 1; gpu_grant in cycle 0 = 0; cpu_ack in cycle 1; gpu_grant = 1 in cycles 1 and 2.
- Window open (h = 200, v = 100), gpu_req held high for 10 cycles, cpu_req read -> 10 consecutive gpu_grants, each with gpu_rdata_valid one cycle later. CPU issues in cycle 10; cpu_ack in cycle 11 carries the value written in scenario 1.
- h_count = 140 -> 141 transition with CPU issue at h = 140 -> cpu_ack at h = 141 while gpu_grant = 1 in the same cycle.
- cpu_req held for 64 cycles inside the window with gpu_req constantly high -> cpu_starved rises at wait count 64. It stays high until h = 0, v = 0, then clears.
- resetn low in an ACK cycle -> no cpu_ack; FSM in IDLE after reset; all outputs at REQ-018/REQ-020 values.
- cpu_req pulsed one cycle inside the window with gpu_req high -> no VRAM access from the CPU and no cpu_ack.
